// File: rtl/lms_upd15.sv
// LMS weight updater: 15-tap delay line, one tap updated per cycle, w' = w + (e*x >>> MU_SHIFT).
// Optional macro LMS_SAT_EN clips each updated tap to 10-bit range and reports it on sat_any.
module lms_upd15 #(
    parameter int unsigned MU_SHIFT = 6
) (
    input  logic         clk,
    input  logic         r,
    input  logic [9:0]   x_in,
    input  logic         x_valid,
    output logic         x_ready,
    input  logic [9:0]   err,
    input  logic         start,
    input  logic [149:0] w_bus,
    output logic [149:0] a_bus,
    output logic         busy,
    output logic         done,
    output logic         sat_any
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e       state_q, state_d;
    logic [3:0]   idx_q;
    logic [9:0]   x_dly_q [15];
    logic [149:0] w_s_q;
    logic [9:0]   err_s_q;
    logic [149:0] a_q;

    logic         accept_start;
    logic         shift_en;
    logic         in_calc;
    logic [9:0]   x_sel;
    logic [9:0]   w_sel;
    logic signed [19:0] x_ext;
    logic signed [19:0] e_ext;
    logic signed [19:0] prod;
    logic signed [19:0] shifted;
    logic signed [20:0] sum;
    logic         clip;
    logic [9:0]   new_tap;

    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StDone);
    assign x_ready      = ~busy;
    assign in_calc      = (state_q == StCalc);
    assign accept_start = (state_q == StIdle) && start;
    assign shift_en     = x_valid && x_ready;
    assign a_bus        = a_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StCalc;
            StCalc:  if (idx_q == 4'd14) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        x_sel = '0;
        w_sel = '0;
        for (int k = 0; k < 15; k++) begin
            if (idx_q == 4'(k)) begin
                x_sel = x_dly_q[k];
                w_sel = w_s_q[k*10 +: 10];
            end
        end
    end

    // Full-precision product, floored shift, then a 21-bit sum so overflow is always visible.
    assign x_ext   = $signed({{10{x_sel[9]}}, x_sel});
    assign e_ext   = $signed({{10{err_s_q[9]}}, err_s_q});
    assign prod    = x_ext * e_ext;
    assign shifted = prod >>> MU_SHIFT;
    assign sum     = $signed({{11{w_sel[9]}}, w_sel}) + $signed({shifted[19], shifted});
    assign clip    = ~((&sum[20:9]) | ~(|sum[20:9]));

`ifdef LMS_SAT_EN
    logic sat_q;

    always_comb begin
        new_tap = sum[9:0];
        if (clip) new_tap = sum[20] ? 10'h200 : 10'h1ff;
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            sat_q <= 1'b0;
        end else if (accept_start) begin
            sat_q <= 1'b0;
        end else if (in_calc && clip) begin
            sat_q <= 1'b1;
        end
    end

    assign sat_any = sat_q;
`else
    logic unused_clip;

    assign new_tap     = sum[9:0];
    assign unused_clip = clip;
    assign sat_any     = 1'b0;
`endif

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept_start) begin
                idx_q <= '0;
            end else if (in_calc) begin
                idx_q <= idx_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            for (int k = 0; k < 15; k++) x_dly_q[k] <= '0;
        end else if (shift_en) begin
            for (int k = 14; k > 0; k--) x_dly_q[k] <= x_dly_q[k-1];
            x_dly_q[0] <= x_in;
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            w_s_q   <= '0;
            err_s_q <= '0;
        end else if (accept_start) begin
            w_s_q   <= w_bus;
            err_s_q <= err;
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            a_q <= '0;
        end else if (in_calc) begin
            for (int k = 0; k < 15; k++) begin
                if (idx_q == 4'(k)) a_q[k*10 +: 10] <= new_tap;
            end
        end
    end

endmodule

// File: doc/lms_upd15.md
LMS_UPD15 -- requirements
Module: lms_upd15

Interface
REQ-001 Parameter MU_SHIFT, default 6, step size mu = 2^-MU_SHIFT, legal range 0..12.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 r  in  1  reset, asynchronous assert, active-low; synchronous deassert is the environment's duty.
REQ-004 x_in  in  10  signed input sample.
REQ-005 x_valid  in  1  x_in is valid this cycle.
REQ-006 x_ready  out  1  high when a sample is accepted; equals ~busy.
REQ-007 err  in  10  signed error e(n); sampled on start accept.
REQ-008 start  in  1  request one weight-update pass.
REQ-009 w_bus  in  150  current weights; tap k at bits [10k+9:10k], k=0..14, signed.
REQ-010 a_bus  out  150  updated weights; same packing; feeds the 15-entry weight register table.
REQ-011 busy  out  1  high from accepted start until done cycle inclusive.
REQ-012 done  out  1  one-cycle pulse; a_bus is complete and stable from this cycle.
REQ-013 sat_any  out  1  valid with done; set if any tap clipped in that pass.

Function
REQ-014 Delay line: 15 x 10-bit regs x_dly[0..14]; x_valid&x_ready shifts x_dly[k]<=x_dly[k-1], x_dly[0]<=x_in.
REQ-015 x_valid while x_ready=0: sample dropped, delay line unchanged.
REQ-016 FSM states IDLE, CALC, DONE; reset state IDLE.
REQ-017 IDLE & start: go CALC, idx<=0; snapshot w_bus and err into internal regs that same edge.
REQ-018 start and x_valid in same IDLE cycle: shift and snapshot on the same edge; CALC uses the shifted line.
REQ-019 start while busy=1: ignored, no queuing.
REQ-020 CALC: one tap per cycle, idx 0..14; after idx 14 go DONE; DONE lasts one cycle, then IDLE.
REQ-021 Latency: start accepted at edge t; done=1 in cycle t+16; busy=1 in cycles t+1..t+16.
REQ-022 Per tap: p = err_s * x_dly[idx] (20-bit signed); d = p >>> MU_SHIFT (arithmetic, floor toward -inf); s = sign-extend(w_s[idx]) + d, computed at 21 bits.
REQ-023 a_bus tap idx is written at the end of its CALC cycle; other taps hold; a_bus changes only in CALC.
REQ-024 Delay line frozen during CALC/DONE, via x_ready=0.
REQ-025 sat_any cleared on start accept, set if any tap clipped, held until next accept.

Reset
REQ-026 r=0 asynchronously forces: state IDLE, a_bus=0, x_dly all 0, snapshots 0, busy=0, done=0, sat_any=0, x_ready=1 after release.
REQ-027 Reset during CALC aborts the pass; no done is produced; a_bus reads 0.

Configuration
REQ-028 Macro LMS_SAT_EN defined: s is clipped to [-512, 511] before write, and clipping sets sat_any.
REQ-029 LMS_SAT_EN undefined: s is truncated to its low 10 bits (two's-complement wrap), and sat_any is tied 0.

Verification
REQ-030 MU_SHIFT=6; shift in x=64 once; err=64; w tap0=100; start -> done at t+16, a tap0=164, taps 1..14 = w unchanged (x=0).
REQ-031 w tap0=500, err=511, x=511: with LMS_SAT_EN, a tap0=511 and sat_any=1; without it, a tap0=484 and sat_any=0.
REQ-032 w tap0=-480, err=-64, x=64: with LMS_SAT_EN, a tap0=-512; without it, a tap0=480.
REQ-033 err=-1, x=1, w=0 -> a tap0=-1 (floor); err=1, x=1, w=0 -> a tap0=0.
REQ-034 Shift 3 samples 10,20,30, then start with x_valid=1 and x_in=40 in the same cycle; x_valid held during busy -> taps 0..3 use 40,30,20,10; samples are dropped while x_ready=0, and a second start mid-pass is ignored.
REQ-035 Assert r=0 at idx 7 of CALC -> all outputs 0 at once, no done pulse; a new start after release completes normally at t+16.
